// File: rtl/gfifo_rx_unpack.sv
// gfifo_rx_unpack: buffers 512-bit GFIFO beats and unpacks them into a 32-bit word stream.
// Optional drained-beat counter is built only when GFIFO_RX_STATS_EN is defined.
module gfifo_rx_unpack #(
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] o_data,
  input  logic         o_data_en,
  input  logic [3:0]   o_data_len,
  output logic         beat_rdy,
  output logic [31:0]  word_data,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         word_last,
  output logic         overflow,
  output logic [31:0]  beat_cnt
);
  localparam int PW = $clog2(BUF_DEPTH);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_next;
  logic [511:0] buf_data [BUF_DEPTH];
  logic [3:0] buf_len [BUF_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] occ, occ_next;
  logic [3:0] idx;
  logic push, xfer, pop;
  assign push = o_data_en && beat_rdy;
  assign xfer = word_valid && word_ready;
  assign pop = xfer && word_last;
  assign occ_next = occ + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= o_data;
      buf_len[wr_ptr] <= o_data_len;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      beat_rdy <= 1'b0;
      overflow <= 1'b0;
      idx <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ_next;
      beat_rdy <= occ_next < (PW+1)'(BUF_DEPTH);
      if (o_data_en && !beat_rdy) overflow <= 1'b1;
      idx <= pop ? 4'd0 : xfer ? idx + 4'd1 : idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  end
  // Looking at the incoming push lets an empty buffer present word 0 the very next cycle.
  always_comb begin
    state_next = state == IDLE ? ((occ != '0 || push) ? DRAIN : IDLE)
                               : ((pop && occ_next == '0) ? IDLE : DRAIN);
  end
  always_comb begin
    word_valid = state == DRAIN;
    word_data = word_valid ? buf_data[rd_ptr][{idx, 5'd0} +: 32] : 32'd0;
    word_last = word_valid && idx == buf_len[rd_ptr];
  end
`ifdef GFIFO_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_cnt <= '0;
    else if (pop) beat_cnt <= beat_cnt + 32'd1;
  end
`else
  assign beat_cnt = '0;
`endif
endmodule

// File: tb/tb_gfifo_rx_unpack.sv
// tb_gfifo_rx_unpack: directed scoreboard bench for gfifo_rx_unpack.
module tb_gfifo_rx_unpack;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [511:0] o_data = '0;
  logic o_data_en = 1'b0;
  logic [3:0] o_data_len = '0;
  logic word_ready = 1'b0;
  logic beat_rdy, word_valid, word_last, overflow;
  logic [31:0] word_data, beat_cnt;
  int checks = 0, failures = 0, exp_beats = 0;
  logic [32:0] q[$];
  logic hold = 1'b0, hl;
  logic [31:0] hd;
  gfifo_rx_unpack dut (
    .clk(clk), .rst_n(rst_n), .o_data(o_data), .o_data_en(o_data_en),
    .o_data_len(o_data_len), .beat_rdy(beat_rdy), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready), .word_last(word_last),
    .overflow(overflow), .beat_cnt(beat_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [511:0] mk(input logic [7:0] s);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = {s, 16'hA500, 8'(k)};
    return r;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [511:0] d, input logic [3:0] len, input bit acc);
    o_data = d;
    o_data_len = len;
    o_data_en = 1'b1;
    if (acc) begin
      for (int k = 0; k <= int'(len); k++) q.push_back({k == int'(len), d[32*k +: 32]});
      exp_beats++;
    end
    step;
    o_data_en = 1'b0;
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      step;
      n++;
    end
    chk("drain_done", 64'(q.size()), 0);
  endtask
  function automatic logic [31:0] exp_cnt(input int n);
`ifdef GFIFO_RX_STATS_EN
    return 32'(n);
`else
    return n == -1 ? 32'd1 : 32'd0;
`endif
  endfunction
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst_n) hold = 1'b0;
    else begin
      if (hold) begin
        chk("hold_valid", 64'(word_valid), 1);
        chk("hold_data", 64'(word_data), 64'(hd));
        chk("hold_last", 64'(word_last), 64'(hl));
      end
      if (word_valid && word_ready) begin
        chk("word_expected", 64'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("word_data", 64'(word_data), 64'(e[31:0]));
          chk("word_last", 64'(word_last), 64'(e[32]));
        end
      end
      hold = word_valid && !word_ready;
      hd = word_data;
      hl = word_last;
    end
  end
  initial begin
    logic [511:0] d;
    logic [3:0] lens [5] = '{4'd0, 4'd3, 4'd7, 4'd15, 4'd2};
    #1;
    chk("rst_valid", 64'(word_valid), 0);
    chk("rst_rdy", 64'(beat_rdy), 0);
    chk("rst_ovf", 64'(overflow), 0);
    chk("rst_cnt", 64'(beat_cnt), 0);
    chk("rst_data", 64'(word_data), 0);
    chk("rst_last", 64'(word_last), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step;
    chk("rdy_after_rst", 64'(beat_rdy), 1);
    word_ready = 1'b1;
    d = '0;
    d[127:0] = {32'h44, 32'h33, 32'h22, 32'h11};
    push(d, 4'd3, 1'b1);
    chk("latency_valid", 64'(word_valid), 1);
    chk("latency_data", 64'(word_data), 64'h11);
    drain(20);
    push(mk(8'd1), 4'd0, 1'b1);
    begin
      int run;
      run = word_valid ? 1 : 0;
      push(mk(8'd2), 4'd15, 1'b1);
      while (word_valid && run < 40) begin
        run++;
        step;
      end
      chk("no_bubble_run", 64'(run), 17);
    end
    chk("b2b_drained", 64'(q.size()), 0);
    d = mk(8'd3);
    word_ready = 1'b0;
    push(d, 4'd1, 1'b1);
    word_ready = 1'b1;
    step;
    word_ready = 1'b0;
    chk("stall_w1_a", 64'(word_data), 64'(d[63:32]));
    step;
    chk("stall_w1_b", 64'(word_data), 64'(d[63:32]));
    word_ready = 1'b1;
    step;
    chk("stall_done", 64'(word_valid), 0);
    chk("stall_q", 64'(q.size()), 0);
    word_ready = 1'b0;
    push(mk(8'd4), 4'd2, 1'b1);
    chk("ovf_rdy1", 64'(beat_rdy), 1);
    push(mk(8'd5), 4'd1, 1'b1);
    chk("ovf_rdy2", 64'(beat_rdy), 0);
    chk("ovf_clear", 64'(overflow), 0);
    push(mk(8'd6), 4'd3, 1'b0);
    chk("ovf_set", 64'(overflow), 1);
    chk("ovf_rdy3", 64'(beat_rdy), 0);
    repeat (3) step;
    chk("ovf_sticky", 64'(overflow), 1);
    word_ready = 1'b1;
    drain(40);
    chk("ovf_sticky2", 64'(overflow), 1);
    chk("ovf_rdy_back", 64'(beat_rdy), 1);
    chk("cnt_pre_rst", 64'(beat_cnt), 64'(exp_cnt(exp_beats)));
    d = mk(8'd7);
    push(d, 4'd15, 1'b1);
    repeat (5) step;
    chk("mid_idx5", 64'(word_data), 64'(d[191:160]));
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_beats = 0;
    chk("mid_rst_valid", 64'(word_valid), 0);
    chk("mid_rst_cnt", 64'(beat_cnt), 0);
    chk("mid_rst_ovf", 64'(overflow), 0);
    chk("mid_rst_rdy", 64'(beat_rdy), 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step;
    chk("mid_rdy_back", 64'(beat_rdy), 1);
    repeat (4) begin
      chk("post_rst_quiet", 64'(word_valid), 0);
      step;
    end
    for (int i = 0; i < 5; i++) begin
      push(mk(8'(8 + i)), lens[i], 1'b1);
      drain(40);
    end
    chk("cnt_five", 64'(beat_cnt), 64'(exp_cnt(exp_beats)));
    chk("final_q", 64'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
